// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            md_op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  flush;
  logic                  stall_req;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, md_op, operand_1, operand_2, flush,
    input  stall_req, busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, operand_1, operand_2, flush,
    output stall_req, busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO with a done pulse.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle one.
module ex_muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_muldiv_unit_if.slave   bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    mcand;
  logic            is_div, neg, rem_neg;
  logic            busy_q, done_q;
  logic [W-1:0]    hi_q, lo_q;

  logic            signed_op, op1_neg, op2_neg, div_zero, fast_mul, accept, accept_iter;
  logic [W-1:0]    op1_abs, op2_abs;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next, div_next, prod_fix;
  logic [W:0]      rem_shift;
  logic [W-1:0]    div_diff, quot_fix, rem_fix;
  logic            div_ge;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]  fast_prod;
`endif

  always_comb begin
    signed_op = ~bus.md_op[0];
    op1_neg   = signed_op & bus.operand_1[W-1];
    op2_neg   = signed_op & bus.operand_2[W-1];
    op1_abs   = op1_neg ? -bus.operand_1 : bus.operand_1;
    op2_abs   = op2_neg ? -bus.operand_2 : bus.operand_2;
    div_zero  = bus.md_op[1] & (bus.operand_2 == '0);
`ifdef MULDIV_FAST_MUL_EN
    fast_mul  = ~bus.md_op[1];
    // Sign-extend to full width; the truncated unsigned product is then the signed product.
    fast_prod = {{W{op1_neg}}, bus.operand_1} * {{W{op2_neg}}, bus.operand_2};
`else
    fast_mul  = 1'b0;
`endif
    accept      = (state == IDLE) & bus.start & ~done_q & ~bus.flush;
    accept_iter = accept & ~fast_mul;
  end

  // One iteration: shift-add multiply (acc = {partial, multiplier}) or
  // restoring divide (acc = {remainder, dividend/quotient}).
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next  = {mul_sum, acc[W-1:1]};
    rem_shift = acc[2*W-1:W-1];
    div_ge    = rem_shift >= {1'b0, mcand};
    div_diff  = rem_shift[W-1:0] - mcand;
    div_next  = div_ge ? {div_diff, acc[W-2:0], 1'b1}
                       : {rem_shift[W-1:0], acc[W-2:0], 1'b0};
    prod_fix  = neg ? -acc : acc;
    quot_fix  = neg ? -acc[W-1:0] : acc[W-1:0];
    rem_fix   = rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_iter) state_next = div_zero ? FIX : CALC;
      CALC:    if (count == CW'(W - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      is_div  <= 1'b0;
      neg     <= 1'b0;
      rem_neg <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_next != IDLE);
      case (state)
        IDLE: begin
`ifdef MULDIV_FAST_MUL_EN
          if (accept && fast_mul) begin
            hi_q   <= fast_prod[2*W-1:W];
            lo_q   <= fast_prod[W-1:0];
            done_q <= 1'b1;
          end
`endif
          if (accept_iter) begin
            count  <= '0;
            is_div <= bus.md_op[1];
            // Divide-by-zero preloads the raw result and clears the sign flags so FIX passes it through.
            if (div_zero) begin
              acc     <= {bus.operand_1, {W{1'b1}}};
              neg     <= 1'b0;
              rem_neg <= 1'b0;
            end else begin
              acc     <= {{W{1'b0}}, bus.md_op[1] ? op1_abs : op2_abs};
              neg     <= op1_neg ^ op2_neg;
              rem_neg <= op1_neg & bus.md_op[1];
            end
            mcand <= bus.md_op[1] ? op2_abs : op1_abs;
          end
        end
        CALC: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          if (!bus.flush) begin
            hi_q   <= is_div ? rem_fix  : prod_fix[2*W-1:W];
            lo_q   <= is_div ? quot_fix : prod_fix[W-1:0];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_req = (bus.start & ~done_q) | busy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule
